data_register: RTL and testbench
================================

// Module: data_register
// PURPOSE
//   Parameterised clocked data register; default is one stage, optionally a
//   shift pipeline of STAGES stages. Used to register/retime datapath words
//   between core blocks.
//   Synchronous reset clears every stage to RESET_VALUE.
//   No handshake: the register samples data_in on every rising clock edge.
// PARAMETERS
//   WIDTH        32   data word width in bits (>=1)
//   STAGES       1    number of register stages = output latency in cycles (>=1)
//   RESET_VALUE  '0   value every stage takes on reset (WIDTH bits)
// PORTS
//   clk       input   1      single clock; all state updates on posedge clk
//   rst       input   1      synchronous reset, ACTIVE-LOW (0 = reset asserted)
//   data_in   input   WIDTH  word to be registered
//   data_out  output  WIDTH  registered word (output of the last stage)
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-low.
//   - The reset port is named rst, as in the codebase, despite its active-low polarity.
//   - At posedge clk with rst==0: every stage <= RESET_VALUE, whatever data_in is.
//     Reset has priority over data.
//   - At posedge clk with rst==1: stage[0] <= data_in, stage[k] <= stage[k-1].
//     data_out = stage[STAGES-1].
//   - Latency:
//     - STAGES==1: data_in sampled at edge N appears on data_out by N+#delta
//       and is held until edge N+1.
//     - General case: data_out at edge N+STAGES-1 equals data_in sampled at edge N.
//   - Hold:
//     - data_out is driven only by flops; no combinational path from data_in.
//     - data_in changes between edges never change data_out.
//   - Reset value: data_out == RESET_VALUE after the first edge with rst==0.
//     Before any edge the output is unspecified (no power-on initialiser).
//   - Reset mid-operation: stored data is discarded at the reset edge.
//     The first edge with rst==1 afterwards loads data_in (STAGES==1); there
//     is no recovery-delay cycle.
//   - Reset held over many cycles: output stays RESET_VALUE every cycle.
//   - Width: full WIDTH bits are stored unmodified. No sign handling, no
//     truncation; MSB and all-ones patterns pass bit-exact.
//   - Back-to-back distinct values on consecutive edges: each one appears for
//     exactly one cycle.
//   - Elaboration checks:
//     - WIDTH<1 or STAGES<1 is a fatal elaboration error.
//     - RESET_VALUE is sized to WIDTH.
// STRUCTURE
//   - Shared package core_pkg: default word width constant (32); no typedefs
//     are needed beyond logic [WIDTH-1:0].
//   - Sub-module data_register_stage: single WIDTH-bit flop with sync
//     active-low reset to RESET_VALUE.
//   - data_register instantiates STAGES of data_register_stage in a generate
//     chain; STAGES==1 degenerates to one instance.
// TESTING (WIDTH=32, STAGES=1, RESET_VALUE=0)
//   1. rst=0, data_in=FFFFFFFF/AAAAAAAA/55555555 on 3 edges
//      -> data_out=00000000 after each edge.
//   2. rst=1, data_in=12345678, ABCDEF00, DEADBEEF, 00000000, FFFFFFFF on
//      successive edges -> data_out equals each value 1 ns after its edge.
//   3. Load 87654321 at an edge, then data_in=11111111 at +1 ns; check at +3.5 ns
//      -> data_out still 87654321.
//   4. data_out=CAFEBABE, then rst=0 with data_in=CAFEBABE for one edge -> 00000000.
//      Next edge rst=1, data_in=FEEDFACE -> FEEDFACE.
//   5. Edge values 00000001, 80000000, 7FFFFFFF, then 0,1,2,3,4 on consecutive
//      edges -> each reproduced bit-exact for exactly one cycle.
//   6. STAGES=3 variant: data_in A,B,C on consecutive edges -> data_out shows
//      A two edges after A is sampled.
//      Reset clears all 3 stages in one edge.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared datapath constants for the core blocks
package core_pkg;
  localparam int WORD_WIDTH = 32;
endpackage

// File: rtl/data_register_stage.sv
// data_register_stage: one WIDTH-bit flop with sync active-low reset to RESET_VALUE
module data_register_stage
  import core_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= !rst ? RESET_VALUE : d;
endmodule

// File: rtl/data_register.sv
// data_register: STAGES-deep retiming register chain, latency STAGES cycles
module data_register
  import core_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);
  if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
    $fatal(1, "data_register: WIDTH and STAGES must be >= 1");
  end
  logic [WIDTH-1:0] chain [STAGES+1];
  assign chain[0] = data_in;
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    data_register_stage #(
      .WIDTH(WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .d(chain[g]),
      .q(chain[g+1])
    );
  end
  assign data_out = chain[STAGES];
endmodule

// File: tb/tb_data_register.sv
// tb_data_register: directed plus random checks of 1- and 3-stage registers against a timeline model
module tb_data_register;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] out1, out3;
  int passed = 0;
  int total = 0;
  int edge_n = 0;
  int last_rst = 0;
  logic [31:0] samp [int];

  always #5 clk = ~clk;

  data_register #(.WIDTH(32), .STAGES(1), .RESET_VALUE('0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(out1)
  );
  data_register #(.WIDTH(32), .STAGES(3), .RESET_VALUE('0)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(out3)
  );

  // Output of an S-stage register after the current edge: the word sampled
  // S-1 edges ago, unless a reset edge happened since that sample.
  function automatic logic [31:0] expect_out(int s);
    int src = edge_n - (s - 1);
    return (src > last_rst) ? samp[src] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic [31:0] d, input string tag);
    @(negedge clk);
    rst = r;
    data_in = d;
    @(posedge clk);
    edge_n++;
    samp[edge_n] = d;
    if (!r) last_rst = edge_n;
    #1;
    chk({tag, "_s1"}, out1, expect_out(1));
    chk({tag, "_s3"}, out3, expect_out(3));
  endtask

  initial begin
    logic [31:0] seq [13];
    seq = '{32'h12345678, 32'hABCDEF00, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF,
            32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
    step(1'b0, 32'hFFFFFFFF, "reset_ff");
    chk("reset_ff_const", out1, 32'h0);
    step(1'b0, 32'hAAAAAAAA, "reset_aa");
    step(1'b0, 32'h55555555, "reset_55");
    chk("reset_55_const", out1, 32'h0);
    foreach (seq[i]) step(1'b1, seq[i], "seq");
    chk("seq_last_const", out1, 32'h4);
    step(1'b1, 32'h87654321, "hold_load");
    data_in = 32'h11111111;
    #2.5;
    chk("hold_mid_cycle", out1, 32'h87654321);
    step(1'b1, 32'hCAFEBABE, "pre_reset");
    step(1'b0, 32'hCAFEBABE, "mid_reset");
    chk("mid_reset_const", out1, 32'h0);
    step(1'b1, 32'hFEEDFACE, "recover");
    chk("recover_const", out1, 32'hFEEDFACE);
    step(1'b1, 32'h0000000A, "s3_a");
    step(1'b1, 32'h0000000B, "s3_b");
    step(1'b1, 32'h0000000C, "s3_c");
    chk("s3_latency_const", out3, 32'h0000000A);
    step(1'b0, 32'h0000000D, "s3_reset");
    chk("s3_reset_const", out3, 32'h0);
    step(1'b1, 32'h0000000E, "s3_after_reset");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 7) != 0, $urandom, "rand");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
